// File: rtl/fetch_align_pkg.sv
// Shared types and helpers for the instruction fetch/alignment unit.
package fetch_align_pkg;

  typedef enum logic [1:0] {
    FetchIdle  = 2'd0,
    FetchWait  = 2'd1,
    FetchFault = 2'd2
  } fetch_state_e;

  localparam int unsigned QueueDepth = 4;
  localparam int unsigned CountWidth = 3;

  // Compressed (16-bit) encodings never have both low bits set.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Four-entry halfword FIFO feeding instruction reassembly; push/pop one or two per cycle.
module fetch_queue
  import fetch_align_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_one_i,
  input  logic                  push_two_i,
  input  logic [31:0]           push_data_i,
  input  logic                  pop_one_i,
  input  logic                  pop_two_i,
  output logic [15:0]           hw0_o,
  output logic [15:0]           hw1_o,
  output logic [CountWidth-1:0] count_o
);

  logic [15:0]           mem_q [QueueDepth];
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [1:0]            wr_ptr, wr_ptr_next, rd_ptr_next;
  logic [CountWidth-1:0] push_cnt, pop_cnt;

  always_comb begin
    push_cnt    = push_two_i ? 3'd2 : (push_one_i ? 3'd1 : 3'd0);
    pop_cnt     = pop_two_i  ? 3'd2 : (pop_one_i  ? 3'd1 : 3'd0);
    // Slots being written are free even with a same-cycle pop: occupancy never exceeds four.
    wr_ptr      = rd_ptr_q + count_q[1:0];
    wr_ptr_next = wr_ptr + 2'd1;
    rd_ptr_next = rd_ptr_q + 2'd1;
    rd_ptr_d    = rd_ptr_q + pop_cnt[1:0];
    count_d     = count_q + push_cnt - pop_cnt;
    if (flush_i) begin
      rd_ptr_d = 2'd0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= 2'd0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (!flush_i) begin
        if (push_two_i) begin
          mem_q[wr_ptr]      <= push_data_i[15:0];
          mem_q[wr_ptr_next] <= push_data_i[31:16];
        end else if (push_one_i) begin
          mem_q[wr_ptr] <= push_data_i[31:16];
        end
      end
    end
  end

  assign hw0_o   = mem_q[rd_ptr_q];
  assign hw1_o   = mem_q[rd_ptr_next];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_align.sv
// Fetch sequencer: issues word reads, reassembles RV32IC instructions and hands them to decode.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  output logic        O_memreq,
  output logic [31:0] O_memaddr,
  input  logic        I_memready,
  input  logic        I_memvalid,
  input  logic [31:0] I_memdata,
  output logic        O_valid,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  input  logic        I_ready,
  input  logic        I_redirect,
  input  logic [31:0] I_redirectpc,
  output logic        O_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_ptr_q, fetch_ptr_d;
  logic         drop_q, drop_d;
  logic         trim_q, trim_d;
  logic         fault_q, fault_d;

  logic [15:0]           hw0, hw1;
  logic [CountWidth-1:0] count;
  logic                  head_rvc;
  logic                  accept, outstanding, inflight_keep, deliver, fire;
  logic                  push_one, push_two, pop_one, pop_two;

  fetch_queue u_queue (
    .clk_i       (I_clk),
    .rst_i       (I_rst),
    .flush_i     (I_redirect),
    .push_one_i  (push_one),
    .push_two_i  (push_two),
    .push_data_i (I_memdata),
    .pop_one_i   (pop_one),
    .pop_two_i   (pop_two),
    .hw0_o       (hw0),
    .hw1_o       (hw1),
    .count_o     (count)
  );

  always_comb begin
    head_rvc = is_rvc(hw0);
    O_valid  = 1'b0;
    O_instr  = head_rvc ? {16'h0000, hw0} : {hw1, hw0};
    if (state_q != FetchFault) begin
      if (head_rvc) begin
        O_valid = (count != 3'd0);
      end else begin
        O_valid = (count >= 3'd2);
      end
    end
  end

  // Two free slots are enough to absorb the single word that may be in flight.
  assign O_memreq  = (state_q == FetchIdle) && (count <= 3'd2) && !I_rst;
  assign O_memaddr = fetch_ptr_q;
  assign O_pc      = pc_q;
  assign O_fault   = fault_q;

  always_comb begin
    accept        = O_memreq && I_memready;
    // A faulted FSM still owes one returning word when it left a request in flight.
    outstanding   = (state_q == FetchWait) || ((state_q == FetchFault) && drop_q);
    inflight_keep = (outstanding && !I_memvalid) || accept;
    deliver       = (state_q == FetchWait) && I_memvalid && !drop_q && !I_redirect;
    push_two      = deliver && !trim_q;
    push_one      = deliver && trim_q;
    fire          = O_valid && I_ready && !I_redirect;
    pop_one       = fire && head_rvc;
    pop_two       = fire && !head_rvc;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_ptr_d = fetch_ptr_q;
    drop_d      = drop_q;
    trim_d      = trim_q;
    fault_d     = fault_q;

    if (fire) begin
      pc_d = pc_q + (head_rvc ? 32'd2 : 32'd4);
    end
    if (deliver) begin
      trim_d = 1'b0;
    end

    unique case (state_q)
      FetchIdle: begin
        if (accept) begin
          state_d     = FetchWait;
          fetch_ptr_d = fetch_ptr_q + 32'd4;
        end
      end
      FetchWait: begin
        if (I_memvalid) begin
          state_d = FetchIdle;
          drop_d  = 1'b0;
        end
      end
      FetchFault: begin
        if (I_memvalid) begin
          drop_d = 1'b0;
        end
      end
      default: state_d = FetchIdle;
    endcase

    if (I_redirect) begin
      pc_d        = I_redirectpc;
      fetch_ptr_d = {I_redirectpc[31:2], 2'b00};
      trim_d      = I_redirectpc[1];
      drop_d      = inflight_keep;
      fault_d     = I_redirectpc[0];
      if (I_redirectpc[0]) begin
        state_d = FetchFault;
      end else begin
        // Wait out a stale word before issuing anything new: only one request may be open.
        state_d = inflight_keep ? FetchWait : FetchIdle;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= FetchIdle;
      pc_q        <= RESET_PC;
      fetch_ptr_q <= {RESET_PC[31:2], 2'b00};
      drop_q      <= 1'b0;
      trim_q      <= RESET_PC[1];
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_ptr_q <= fetch_ptr_d;
      drop_q      <= drop_d;
      trim_q      <= trim_d;
      fault_q     <= fault_d;
    end
  end

endmodule
